// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: eight-digit multiplexed seven-segment scan driver with per-digit dp and blink.
//   clk, rst        clock, synchronous active-high reset
//   EN              reload shadow content at frame boundary
//   Disp_num        display word, digit i = Disp_num[4i+3:4i], digit 0 rightmost
//   point_in        per-digit decimal point enable
//   blink_in        per-digit blink enable
//   AN              active-low digit enables
//   SEGMENT         active-low {dp,g,f,e,d,c,b,a}
//   frame_done      one-cycle pulse after each completed frame
module seg7_scan_drv #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [31:0] Disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  blink_in,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_done
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  // Segment patterns a..g for nibbles F..0, one byte per nibble, nibble 0 in the low byte
  localparam logic [127:0] SEG_LUT = 128'h8E86A1C683889080F8829299B0A4F9C0;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
  logic [31:0]   sdata_q, sdata_d;
  logic [7:0]    spoint_q, spoint_d;
  logic [7:0]    sblink_q, sblink_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          done_q, done_d;
  logic          tick, bound, fwrap, blank;
  logic [3:0]    nib;
  always_comb begin
    tick     = pcnt_q == PW'(SCAN_DIV - 1);
    bound    = tick && idx_q == 3'd7;
    fwrap    = fcnt_q == FW'(BLINK_FRAMES - 1);
    pcnt_d   = tick ? '0 : pcnt_q + 1'b1;
    idx_d    = idx_q + {2'b00, tick};
    fcnt_d   = !bound ? fcnt_q : fwrap ? '0 : fcnt_q + 1'b1;
    phase_d  = phase_q ^ (bound && fwrap);
    sdata_d  = bound && EN ? Disp_num : sdata_q;
    spoint_d = bound && EN ? point_in : spoint_q;
    sblink_d = bound && EN ? blink_in : sblink_q;
    done_d   = bound;
    // Outputs follow the digit currently selected, so they lag idx by one cycle
    nib      = sdata_q[{idx_q, 2'b00} +: 4];
    blank    = sblink_q[idx_q] && phase_q;
    an_d     = blank ? 8'hFF : ~(8'h01 << idx_q);
    seg_d    = blank ? 8'hFF : {~spoint_q[idx_q], SEG_LUT[{nib, 3'b000} +: 7]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q   <= '0;
      idx_q    <= '0;
      fcnt_q   <= '0;
      phase_q  <= 1'b0;
      sdata_q  <= '0;
      spoint_q <= '0;
      sblink_q <= '0;
      an_q     <= 8'hFF;
      seg_q    <= 8'hFF;
      done_q   <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      fcnt_q   <= fcnt_d;
      phase_q  <= phase_d;
      sdata_q  <= sdata_d;
      spoint_q <= spoint_d;
      sblink_q <= sblink_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      done_q   <= done_d;
    end
  end
  assign AN         = an_q;
  assign SEGMENT    = seg_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb_seg7_scan_drv: directed self-checking bench for seg7_scan_drv with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg7_scan_drv;
  logic        clk = 1'b0;
  logic        rst;
  logic        EN;
  logic [31:0] Disp_num;
  logic [7:0]  point_in;
  logic [7:0]  blink_in;
  logic [7:0]  AN;
  logic [7:0]  SEGMENT;
  logic        frame_done;
  int checks = 0;
  int fails  = 0;
  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  seg7_scan_drv #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .EN(EN), .Disp_num(Disp_num), .point_in(point_in),
    .blink_in(blink_in), .AN(AN), .SEGMENT(SEGMENT), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Steps through digit slots lo..hi of a frame, 4 cycles each, checking every cycle
  task automatic run_slots(input string tag, input logic [31:0] word, input logic [7:0] pt,
                           input logic [7:0] blanked, input int lo, input int hi);
    logic [7:0] an_e, seg_e;
    for (int j = lo; j <= hi; j++)
      for (int c = 0; c < 4; c++) begin
        @(posedge clk);
        #1;
        an_e  = blanked[j] ? 8'hFF : ~(8'h01 << j);
        seg_e = blanked[j] ? 8'hFF : (hex_tab[word[4*j +: 4]] & ~{pt[j], 7'b0});
        chk($sformatf("%s_d%0d_c%0d_an", tag, j, c), {24'b0, AN}, {24'b0, an_e});
        chk($sformatf("%s_d%0d_c%0d_seg", tag, j, c), {24'b0, SEGMENT}, {24'b0, seg_e});
        chk($sformatf("%s_d%0d_c%0d_done", tag, j, c), {31'b0, frame_done}, {31'b0, j == 7 && c == 3});
      end
  endtask
  initial begin
    rst = 1'b1;
    EN = 1'b1;
    Disp_num = 32'h0;
    point_in = 8'h0;
    blink_in = 8'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst%0d_an", i), {24'b0, AN}, 32'hFF);
      chk($sformatf("rst%0d_seg", i), {24'b0, SEGMENT}, 32'hFF);
      chk($sformatf("rst%0d_done", i), {31'b0, frame_done}, 32'h0);
    end
    rst = 1'b0;
    Disp_num = 32'h89ABCDEF;
    run_slots("f1", 32'h0, 8'h0, 8'h0, 0, 7);
    run_slots("f2", 32'h89ABCDEF, 8'h0, 8'h0, 0, 3);
    Disp_num = 32'h0;
    EN = 1'b0;
    run_slots("f2", 32'h89ABCDEF, 8'h0, 8'h0, 4, 7);
    run_slots("f3", 32'h89ABCDEF, 8'h0, 8'h0, 0, 3);
    EN = 1'b1;
    run_slots("f3", 32'h89ABCDEF, 8'h0, 8'h0, 4, 7);
    run_slots("f4", 32'h0, 8'h0, 8'h0, 0, 3);
    Disp_num = 32'h89ABCDEF;
    point_in = 8'h81;
    blink_in = 8'h80;
    run_slots("f4", 32'h0, 8'h0, 8'h0, 4, 7);
    run_slots("f5", 32'h89ABCDEF, 8'h81, 8'h00, 0, 7);
    run_slots("f6", 32'h89ABCDEF, 8'h81, 8'h00, 0, 7);
    run_slots("f7", 32'h89ABCDEF, 8'h81, 8'h80, 0, 7);
    run_slots("f8", 32'h89ABCDEF, 8'h81, 8'h80, 0, 7);
    run_slots("f9", 32'h89ABCDEF, 8'h81, 8'h00, 0, 7);
    run_slots("f10", 32'h89ABCDEF, 8'h81, 8'h00, 0, 4);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mrst%0d_an", i), {24'b0, AN}, 32'hFF);
      chk($sformatf("mrst%0d_seg", i), {24'b0, SEGMENT}, 32'hFF);
      chk($sformatf("mrst%0d_done", i), {31'b0, frame_done}, 32'h0);
    end
    rst = 1'b0;
    run_slots("post", 32'h0, 8'h0, 8'h0, 0, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_drv.md
# seg7_scan_drv

Eight-digit multiplexed seven-segment scan driver. Consumes the 32-bit display word, per-digit decimal-point mask and per-digit blink mask produced by the display channel multiplexer. Scans one digit at a time, decodes its hex nibble to active-low segments and blanks blinking digits on a slow phase. Sits between the channel multiplexer and the board's AN/SEGMENT pins.

## Interface

Parameters:
- SCAN_DIV, default 50000: clk cycles per digit slot; legal range ≥ 2.
- BLINK_FRAMES, default 64: full 8-digit frames per blink half-period; legal range ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- EN  input  1  1 = shadow registers reload at frame boundary; 0 = displayed content frozen.
- Disp_num  input  32  display word; digit i shows Disp_num[4i+3:4i], digit 0 rightmost.
- point_in  input  8  bit i = 1 lights decimal point of digit i.
- blink_in  input  8  bit i = 1 makes digit i blink.
- AN  output  8  digit enables, active-low, one-hot-low or all-high.
- SEGMENT  output  8  {dp,g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse per completed frame.

## Operation

- Prescaler pcnt counts 0..SCAN_DIV-1 and wraps. tick = (pcnt == SCAN_DIV-1).
- Digit index idx (3 bits) increments on tick; wraps 7 -> 0.
- Frame boundary = tick while idx == 7. On that edge:
  - if EN: shadow_data <= Disp_num, shadow_point <= point_in, shadow_blink <= blink_in;
  - frame_done <= 1 (0 on every other edge);
  - frame counter fcnt counts 0..BLINK_FRAMES-1; on wrap, blink_phase toggles.
- Disp_num/point_in/blink_in changes between boundaries never affect the display.
- Output registers, updated every cycle from current idx and shadow:
  - if shadow_blink[idx] and blink_phase == 1: AN <= 8'hFF, SEGMENT <= 8'hFF;
  - else AN <= ~(8'h01 << idx), SEGMENT[6:0] <= decode(nibble idx), SEGMENT[7] <= ~shadow_point[idx].
- Decode (SEGMENT with dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.

## Timing

- Reset (rst high at a rising edge): pcnt 0, idx 0, fcnt 0, blink_phase 0, shadow_data 0, shadow_point 0, shadow_blink 0, AN 8'hFF, SEGMENT 8'hFF, frame_done 0.
- First cycle after reset release: AN = 8'hFE, SEGMENT = 8'hC0.
- AN/SEGMENT lag idx by one cycle; each digit is held exactly SCAN_DIV cycles; frame = 8·SCAN_DIV cycles.
- frame_done is high in the cycle after the boundary edge. The first frame_done comes 8·SCAN_DIV cycles after reset release.
- New shadow content first appears on the digit-0 slot that starts after the boundary, one cycle after frame_done rises.
- Blink: digit visible for BLINK_FRAMES frames, blanked for BLINK_FRAMES frames. Non-blink digits are unaffected.
- Reset mid-scan overrides all activity in the same edge. Counters restart at 0 and no frame_done is issued.
- EN low at the boundary: no reload. fcnt/blink_phase still advance and frame_done still pulses.

## Test plan

- SCAN_DIV=4: reset 3 cycles -> AN=FF/SEGMENT=FF during reset. After release, AN steps FE,FD,FB,F7,EF,DF,BF,7F,FE every 4 cycles with SEGMENT=C0. frame_done high once, 32 cycles after release.
- Disp_num=32'h89ABCDEF, EN=1 -> after first frame_done, slot AN=FE shows SEGMENT=8E, AN=FD 86, AN=FB A1, AN=F7 C6, AN=EF 83, AN=DF 88, AN=BF 90, AN=7F 80.
- Disp_num changed to 32'h0 mid-frame -> current frame unchanged. With EN=0 at the next boundary, 89ABCDEF is still shown. With EN=1 at the following boundary, all digits show C0.
- point_in=8'h81, Disp_num=32'h89ABCDEF -> digit0 SEGMENT=0E, digit7 SEGMENT=00, others with dp bit 1.
- SCAN_DIV=4, BLINK_FRAMES=2, blink_in=8'h80 -> digit7 visible in frames 1-2 (after load) and blanked (AN=FF, SEGMENT=FF for its 4-cycle slot) in frames 3-4. Other digits never blank.
- rst asserted while idx=5 -> next cycle AN=FF, SEGMENT=FF. After release, scan restarts at AN=FE showing C0 (shadow cleared), and frame_done stays low until 32 cycles later.
